// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/D memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam logic [2:0] FUNCT3_LW            = 3'd2;
  localparam int         DEFAULT_STARVE_LIMIT = 4;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner selection between fetch and data requesters, with a saturating
// counter that forces IF to win after STARVE_LIMIT consecutive D grants.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
  parameter int CNT_W        = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   if_req,
  input  logic   d_req,
  output owner_e winner
);

  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt;
  logic             starved;

  assign starved = (cnt >= LIMIT);

  // No grant may leave the arbiter while reset is held, even though
  // requests may already be presented.
  always_comb begin
    winner = OWN_NONE;
    if (rst_n) begin
      if (if_req && d_req) winner = starved ? OWN_IF : OWN_D;
      else if (if_req)     winner = OWN_IF;
      else if (d_req)      winner = OWN_D;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!if_req || winner == OWN_IF) begin
      cnt <= '0;
    end else if (winner == OWN_D && cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Optional MEM_ARB_RVFI_EN adds read/write byte-mask passthrough for D.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_funct3,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_value,
  output logic [2:0]  mem_funct3,
  output logic        mem_read,
  output logic        mem_write,
`ifdef MEM_ARB_RVFI_EN
  input  logic [3:0]  mem_rmask,
  input  logic [3:0]  mem_wmask,
  output logic [3:0]  d_rmask,
  output logic [3:0]  d_wmask,
`endif
  input  logic [31:0] mem_data
);

  owner_e winner;
  owner_e owner_q;
  logic   store_q;

  mem_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_prio (
    .clk    (clk),
    .rst_n  (rst_n),
    .if_req (if_req),
    .d_req  (d_req),
    .winner (winner)
  );

  assign if_gnt = (winner == OWN_IF);
  assign d_gnt  = (winner == OWN_D);

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    mem_addr   = '0;
    mem_value  = '0;
    mem_funct3 = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    case (winner)
      OWN_IF: begin
        mem_addr   = if_addr;
        mem_funct3 = FUNCT3_LW;
        mem_read   = 1'b1;
      end
      OWN_D: begin
        mem_addr   = d_addr;
        mem_value  = d_wdata;
        mem_funct3 = d_funct3;
        mem_read   = ~d_we;
        mem_write  = d_we;
      end
      default: ;
    endcase
  end

  // Response ownership; reset drops any in-flight response outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
      store_q <= 1'b0;
    end else begin
      owner_q <= winner;
      store_q <= (winner == OWN_D) && d_we;
    end
  end

  assign if_rvalid = (owner_q == OWN_IF);
  assign d_rvalid  = (owner_q == OWN_D);
  assign if_rdata  = if_rvalid ? mem_data : '0;
  assign d_rdata   = (d_rvalid && !store_q) ? mem_data : '0;

`ifdef MEM_ARB_RVFI_EN
  assign d_rmask = d_rvalid ? mem_rmask : '0;
  assign d_wmask = d_rvalid ? mem_wmask : '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a behavioural model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_data;
  logic [2:0]  d_funct3;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_read, mem_write;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_value;
  logic [2:0]  mem_funct3;
`ifdef MEM_ARB_RVFI_EN
  logic [3:0]  mem_rmask, mem_wmask, d_rmask, d_wmask;
`endif

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_funct3(d_funct3), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_value(mem_value), .mem_funct3(mem_funct3),
    .mem_read(mem_read), .mem_write(mem_write),
`ifdef MEM_ARB_RVFI_EN
    .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
    .d_rmask(d_rmask), .d_wmask(d_wmask),
`endif
    .mem_data(mem_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_funct3;
    logic [31:0] mem_data;
    logic        e_if_gnt;
    logic        e_d_gnt;
    logic        e_rd;
    logic        e_wr;
    logic [31:0] e_addr;
    logic [2:0]  e_f3;
    logic [31:0] e_val;
    logic        e_if_rv;
    logic        e_d_rv;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0;
    d_addr = 0; d_wdata = 0; d_funct3 = 0;
  endtask

  // Model state for randomized traffic
  owner_e m_owner, win;
  logic   m_store;
  int     d_run;
  logic [31:0] e_addr, e_val;
  logic [2:0]  e_f3;
  logic        e_rd, e_wr;

  initial begin
    idle_inputs();
    mem_data = 0;
`ifdef MEM_ARB_RVFI_EN
    mem_rmask = 0; mem_wmask = 0;
`endif
    rst_n = 0;
    if_req = 1; d_req = 1;
    @(negedge clk);
    check("reset_if_gnt", {31'd0, if_gnt}, 0);
    check("reset_d_gnt", {31'd0, d_gnt}, 0);
    check("reset_if_rvalid", {31'd0, if_rvalid}, 0);
    check("reset_d_rvalid", {31'd0, d_rvalid}, 0);
    check("reset_mem_read", {31'd0, mem_read}, 0);
    idle_inputs();
    next_cycle();
    rst_n = 1;

    // Directed vectors: each row is one cycle; rvalid/rdata reflect the previous row.
    vecs[0] = '{1, 32'd5,     0, 0, 0,         0,     3'd0, 32'h0,
                1, 0, 1, 0, 32'd5,     3'd2, 32'h0,  0, 0, 32'h0};
    vecs[1] = '{0, 0,         0, 0, 0,         0,     3'd0, 32'h00A00093,
                0, 0, 0, 0, 32'h0,     3'd0, 32'h0,  1, 0, 32'h00A00093};
    vecs[2] = '{0, 0,         1, 1, 32'd3,     32'hFF, 3'd0, 32'h0,
                0, 1, 0, 1, 32'd3,     3'd0, 32'hFF, 0, 0, 32'h0};
    vecs[3] = '{0, 0,         0, 0, 0,         0,     3'd0, 32'hDEADBEEF,
                0, 0, 0, 0, 32'h0,     3'd0, 32'h0,  0, 1, 32'h0};
    vecs[4] = '{1, 32'h100,   0, 0, 0,         0,     3'd0, 32'h0,
                1, 0, 1, 0, 32'h100,   3'd2, 32'h0,  0, 0, 32'h0};
    vecs[5] = '{0, 0,         1, 0, 32'h200,   32'h55, 3'd2, 32'h11111111,
                0, 1, 1, 0, 32'h200,   3'd2, 32'h55, 1, 0, 32'h11111111};
    vecs[6] = '{0, 0,         0, 0, 0,         0,     3'd0, 32'h22222222,
                0, 0, 0, 0, 32'h0,     3'd0, 32'h0,  0, 1, 32'h22222222};
    vecs[7] = '{0, 0,         1, 0, 32'h40,    0,     3'd7, 32'h0,
                0, 1, 1, 0, 32'h40,    3'd7, 32'h0,  0, 0, 32'h0};
    vecs[8] = '{0, 0,         0, 0, 0,         0,     3'd0, 32'h33333333,
                0, 0, 0, 0, 32'h0,     3'd0, 32'h0,  0, 1, 32'h33333333};
    vecs[9] = '{0, 0,         0, 0, 0,         0,     3'd0, 32'h44444444,
                0, 0, 0, 0, 32'h0,     3'd0, 32'h0,  0, 0, 32'h0};

    for (int i = 0; i < 10; i++) begin
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      d_req = vecs[i].d_req; d_we = vecs[i].d_we; d_addr = vecs[i].d_addr;
      d_wdata = vecs[i].d_wdata; d_funct3 = vecs[i].d_funct3;
      mem_data = vecs[i].mem_data;
      @(negedge clk);
      check($sformatf("v%0d_if_gnt", i), {31'd0, if_gnt}, {31'd0, vecs[i].e_if_gnt});
      check($sformatf("v%0d_d_gnt", i), {31'd0, d_gnt}, {31'd0, vecs[i].e_d_gnt});
      check($sformatf("v%0d_mem_read", i), {31'd0, mem_read}, {31'd0, vecs[i].e_rd});
      check($sformatf("v%0d_mem_write", i), {31'd0, mem_write}, {31'd0, vecs[i].e_wr});
      check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
      check($sformatf("v%0d_mem_funct3", i), {29'd0, mem_funct3}, {29'd0, vecs[i].e_f3});
      check($sformatf("v%0d_mem_value", i), mem_value, vecs[i].e_val);
      check($sformatf("v%0d_if_rvalid", i), {31'd0, if_rvalid}, {31'd0, vecs[i].e_if_rv});
      check($sformatf("v%0d_d_rvalid", i), {31'd0, d_rvalid}, {31'd0, vecs[i].e_d_rv});
      if (vecs[i].e_if_rv) check($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].e_rdata);
      if (vecs[i].e_d_rv)  check($sformatf("v%0d_d_rdata", i), d_rdata, vecs[i].e_rdata);
      next_cycle();
    end

    // Contention: both held, expect D,D,D,D,IF repeating.
    if_req = 1; if_addr = 32'h80; d_req = 1; d_we = 0; d_addr = 32'h90; d_funct3 = 3'd2;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check($sformatf("cont%0d_if_gnt", k), {31'd0, if_gnt}, {31'd0, (k % 5) == 4});
      check($sformatf("cont%0d_d_gnt", k), {31'd0, d_gnt}, {31'd0, (k % 5) != 4});
      next_cycle();
    end

    // Reset mid-op: two D grants build up the counter, then reset after a grant.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("pre_rst%0d_d_gnt", k), {31'd0, d_gnt}, 1);
      next_cycle();
    end
    check("pre_rst_d_rvalid", {31'd0, d_rvalid}, 1);
    rst_n = 0;
    #1;
    check("async_rst_d_rvalid", {31'd0, d_rvalid}, 0);
    check("async_rst_if_rvalid", {31'd0, if_rvalid}, 0);
    check("async_rst_d_gnt", {31'd0, d_gnt}, 0);
    check("async_rst_if_gnt", {31'd0, if_gnt}, 0);
    next_cycle();
    next_cycle();
    check("in_rst_d_rvalid", {31'd0, d_rvalid}, 0);
    rst_n = 1;
    #1;
    check("post_rst_d_rvalid", {31'd0, d_rvalid}, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("post_rst%0d_if_gnt", k), {31'd0, if_gnt}, {31'd0, k == 4});
      check($sformatf("post_rst%0d_d_gnt", k), {31'd0, d_gnt}, {31'd0, k != 4});
      next_cycle();
    end
    idle_inputs();
    next_cycle();

`ifdef MEM_ARB_RVFI_EN
    d_req = 1; d_we = 0; d_addr = 32'h10; d_funct3 = 3'd1;
    mem_rmask = 4'b0011;
    next_cycle();
    idle_inputs();
    if_req = 1; if_addr = 32'h20;
    @(negedge clk);
    check("rvfi_d_rvalid", {31'd0, d_rvalid}, 1);
    check("rvfi_d_rmask", {28'd0, d_rmask}, 4'b0011);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("rvfi_if_rvalid", {31'd0, if_rvalid}, 1);
    check("rvfi_if_d_rmask", {28'd0, d_rmask}, 0);
    next_cycle();
    mem_rmask = 0;
    next_cycle();
`endif

    // Randomized traffic against a behavioural model.
    m_owner = OWN_NONE; m_store = 0; d_run = 0;
    for (int c = 0; c < 400; c++) begin
      mem_data = $urandom;
      if (if_req && d_req) win = (d_run >= LIMIT) ? OWN_IF : OWN_D;
      else if (if_req)     win = OWN_IF;
      else if (d_req)      win = OWN_D;
      else                 win = OWN_NONE;
      e_addr = 0; e_val = 0; e_f3 = 0; e_rd = 0; e_wr = 0;
      if (win == OWN_IF) begin
        e_addr = if_addr; e_rd = 1; e_f3 = 3'd2;
      end else if (win == OWN_D) begin
        e_addr = d_addr; e_val = d_wdata; e_f3 = d_funct3; e_rd = ~d_we; e_wr = d_we;
      end
      @(negedge clk);
      check("rnd_if_gnt", {31'd0, if_gnt}, {31'd0, win == OWN_IF});
      check("rnd_d_gnt", {31'd0, d_gnt}, {31'd0, win == OWN_D});
      check("rnd_mem_addr", mem_addr, e_addr);
      check("rnd_mem_value", mem_value, e_val);
      check("rnd_mem_ctrl", {27'd0, mem_funct3, mem_read, mem_write}, {27'd0, e_f3, e_rd, e_wr});
      check("rnd_if_rvalid", {31'd0, if_rvalid}, {31'd0, m_owner == OWN_IF});
      check("rnd_d_rvalid", {31'd0, d_rvalid}, {31'd0, m_owner == OWN_D});
      check("rnd_one_rvalid", {31'd0, if_rvalid & d_rvalid}, 0);
      if (m_owner == OWN_IF) check("rnd_if_rdata", if_rdata, mem_data);
      if (m_owner == OWN_D) check("rnd_d_rdata", d_rdata, m_store ? 32'h0 : mem_data);
      if (!if_req || win == OWN_IF) d_run = 0;
      else if (win == OWN_D && d_run < 15) d_run++;
      m_owner = win;
      m_store = d_we;
      next_cycle();
      if (win == OWN_IF || !if_req) begin
        if_req = ($urandom_range(0, 3) != 0);
        if_addr = $urandom;
      end
      if (win == OWN_D || !d_req) begin
        d_req = ($urandom_range(0, 3) != 0);
        d_we = 1'($urandom_range(0, 1));
        d_addr = $urandom;
        d_wdata = $urandom;
        d_funct3 = 3'($urandom_range(0, 7));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
